true_dual_port_ram: RTL and testbench

Parameterised true dual-port synchronous RAM: two independent read/write ports (A, B) on one clock, with selectable read-during-write mode and defined cross-port collision behaviour. It is the next generation of the team's single-port RAM and serves as shared storage between two masters, such as a producer/consumer pair or a CPU plus DMA. Read data is registered and qualified by a valid strobe.

---
 rtl/true_dual_port_ram.sv | 216 +++++++++++++++++++++
 tb/tb_true_dual_port_ram.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/true_dual_port_ram.sv
// true_dual_port_ram: two independent read/write ports (A, B) sharing one clock
// and one storage array. Read data is registered and qualified by valid_a/b.
// Same-port read-during-write follows MODE. On a same-word collision port A's
// write wins and a reading port sees the pre-write contents.
// Optional macro DPRAM_OUT_REG_EN adds a second output register stage per port,
// which delays data_out, valid, collision and addr_err by one more cycle.
module true_dual_port_ram #(
  parameter int    DEPTH      = 64,
  parameter int    WIDTH      = 8,
  parameter string MODE       = "NO_CHANGE",
  parameter int    ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic                  wr_en_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [WIDTH-1:0]      data_in_a,
  output logic [WIDTH-1:0]      data_out_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic                  wr_en_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [WIDTH-1:0]      data_in_b,
  output logic [WIDTH-1:0]      data_out_b,
  output logic                  valid_b,
  output logic                  collision,
  output logic                  addr_err
);

  localparam bit MODE_WF = (MODE == "WRITE_FIRST");
  localparam bit MODE_RF = (MODE == "READ_FIRST");
  localparam bit MODE_NC = (MODE == "NO_CHANGE");
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

  if (!(MODE_WF || MODE_RF || MODE_NC)) begin : g_bad_mode
    $error("true_dual_port_ram: unsupported MODE \"%s\"", MODE);
  end

  // Storage is deliberately left without reset so it maps onto block RAM.
  logic [WIDTH-1:0]      mem [0:DEPTH-1];

  logic [1:0]            en;
  logic [1:0]            we;
  logic [1:0]            in_range;
  logic [1:0]            wr_commit;
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [WIDTH-1:0]      din    [2];
  logic [WIDTH-1:0]      rd_old [2];
  logic                  same_word;
  logic                  armed_d, armed_q;
  logic                  collision_d, collision_q;
  logic                  addr_err_d, addr_err_q;

  assign en      = {en_b, en_a};
  assign we      = {wr_en_b, wr_en_a};
  assign addr[0] = addr_a;
  assign addr[1] = addr_b;
  assign din[0]  = data_in_a;
  assign din[1]  = data_in_b;

  assign same_word = in_range[0] & in_range[1] & (addr[0] == addr[1]);

  // Port A always wins a same-word write; port B's write is dropped then.
  assign wr_commit[0] = armed_q & en[0] & we[0] & in_range[0];
  assign wr_commit[1] = armed_q & en[1] & we[1] & in_range[1]
                      & ~(wr_commit[0] & same_word);

  // armed_q stays low through the first edge after reset release, so an
  // access sampled on that edge is ignored and nothing commits during reset.
  always_comb begin
    armed_d = 1'b1;
  end

  // Arming flop, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end

  // Write both ports into the array; wr_commit already resolves conflicts.
  always_ff @(posedge clk) begin
    if (wr_commit[0]) begin
      mem[addr[0]] <= din[0];
    end
    if (wr_commit[1]) begin
      mem[addr[1]] <= din[1];
    end
  end

  // Collision and range-error flags for the accesses on this edge.
  always_comb begin
    collision_d = armed_q & en[0] & en[1] & same_word & (we[0] | we[1]);
    addr_err_d  = armed_q & ((en[0] & ~in_range[0]) | (en[1] & ~in_range[1]));
  end

  // First-stage flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      collision_q <= collision_d;
      addr_err_q  <= addr_err_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;

    // rd_old is the word as it was before this edge's writes land, which
    // gives read-first and cross-port "old data" behaviour for free.
    assign in_range[gi] = ({1'b0, addr[gi]} < DEPTH_EXT);
    assign rd_old[gi]   = in_range[gi] ? mem[addr[gi]] : '0;

    // Next output word/valid for this port, by access type and MODE.
    always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      if (armed_q && en[gi]) begin
        if (!in_range[gi]) begin
          data_d  = '0;
          valid_d = 1'b1;
        end else if (!we[gi]) begin
          data_d  = rd_old[gi];
          valid_d = 1'b1;
        end else if (MODE_WF) begin
          data_d  = din[gi];
          valid_d = 1'b1;
        end else if (MODE_RF) begin
          data_d  = rd_old[gi];
          valid_d = 1'b1;
        end
      end
    end

    // First-stage output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

`ifdef DPRAM_OUT_REG_EN
    logic [WIDTH-1:0] data2_d, data2_q;
    logic             valid2_d, valid2_q;

    // Second stage only takes new data when the first stage was valid.
    always_comb begin
      data2_d  = valid_q ? data_q : data2_q;
      valid2_d = valid_q;
    end

    // Second-stage output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data2_q  <= '0;
        valid2_q <= 1'b0;
      end else begin
        data2_q  <= data2_d;
        valid2_q <= valid2_d;
      end
    end

    assign data_out  = data2_q;
    assign valid_out = valid2_q;
`else
    assign data_out  = data_q;
    assign valid_out = valid_q;
`endif
  end

`ifdef DPRAM_OUT_REG_EN
  logic collision2_d, collision2_q;
  logic addr_err2_d, addr_err2_q;

  // Flags travel through the same extra stage as the data they describe.
  always_comb begin
    collision2_d = collision_q;
    addr_err2_d  = addr_err_q;
  end

  // Second-stage flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision2_q <= 1'b0;
      addr_err2_q  <= 1'b0;
    end else begin
      collision2_q <= collision2_d;
      addr_err2_q  <= addr_err2_d;
    end
  end

  assign collision = collision2_q;
  assign addr_err  = addr_err2_q;
`else
  assign collision = collision_q;
  assign addr_err  = addr_err_q;
`endif

  assign data_out_a = g_port[0].data_out;
  assign valid_a    = g_port[0].valid_out;
  assign data_out_b = g_port[1].data_out;
  assign valid_b    = g_port[1].valid_out;

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Bench for true_dual_port_ram: three instances share one stimulus stream
// (DEPTH 64 NO_CHANGE, DEPTH 64 WRITE_FIRST, DEPTH 48 READ_FIRST). A word-level
// model predicts every output each cycle; literal checks pin key scenarios.
module tb_true_dual_port_ram;

`ifdef DPRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, we_a, en_b, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] din_a, din_b;

  logic [7:0] dout_a [3];
  logic [7:0] dout_b [3];
  logic       va [3];
  logic       vb [3];
  logic       col [3];
  logic       aerr [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  true_dual_port_ram #(.DEPTH(64), .WIDTH(8), .MODE("NO_CHANGE")) u_nc (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .wr_en_a(we_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(dout_a[0]), .valid_a(va[0]),
    .en_b(en_b), .wr_en_b(we_b), .addr_b(addr_b), .data_in_b(din_b),
    .data_out_b(dout_b[0]), .valid_b(vb[0]),
    .collision(col[0]), .addr_err(aerr[0]));

  true_dual_port_ram #(.DEPTH(64), .WIDTH(8), .MODE("WRITE_FIRST")) u_wf (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .wr_en_a(we_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(dout_a[1]), .valid_a(va[1]),
    .en_b(en_b), .wr_en_b(we_b), .addr_b(addr_b), .data_in_b(din_b),
    .data_out_b(dout_b[1]), .valid_b(vb[1]),
    .collision(col[1]), .addr_err(aerr[1]));

  true_dual_port_ram #(.DEPTH(48), .WIDTH(8), .MODE("READ_FIRST")) u_rf48 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .wr_en_a(we_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(dout_a[2]), .valid_a(va[2]),
    .en_b(en_b), .wr_en_b(we_b), .addr_b(addr_b), .data_in_b(din_b),
    .data_out_b(dout_b[2]), .valid_b(vb[2]),
    .collision(col[2]), .addr_err(aerr[2]));

  // ---------------- model: 0=NO_CHANGE 1=WRITE_FIRST 2=READ_FIRST ----------
  int         dep  [3] = '{64, 64, 48};
  int         mode [3] = '{0, 1, 2};
  logic [7:0] m_mem   [3][64];
  bit         m_known [3][64];
  bit         m_armed;
  bit         e_v [3][2];
  logic [7:0] e_d [3][2];
  bit         e_k [3][2];
  bit         e_c [3];
  bit         e_a [3];
  bit         p_v [3][2];
  logic [7:0] p_d [3][2];
  bit         p_k [3][2];
  bit         p_c [3];
  bit         p_a [3];

  task automatic model_reset();
    m_armed = 1'b0;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        e_v[d][p] = 1'b0; e_d[d][p] = 8'h00; e_k[d][p] = 1'b1;
        p_v[d][p] = 1'b0; p_d[d][p] = 8'h00; p_k[d][p] = 1'b1;
      end
      e_c[d] = 1'b0; e_a[d] = 1'b0; p_c[d] = 1'b0; p_a[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit idle);
    for (int d = 0; d < 3; d++) begin
      bit         ten [2];
      bit         twe [2];
      bit         inr [2];
      bit         rv  [2];
      bit         rk  [2];
      logic [7:0] rd  [2];
      logic [7:0] td  [2];
      int         ta  [2];
      bit         rc, ra;
      ten[0] = !idle && en_a; twe[0] = we_a; ta[0] = int'(addr_a); td[0] = din_a;
      ten[1] = !idle && en_b; twe[1] = we_b; ta[1] = int'(addr_b); td[1] = din_b;
      for (int p = 0; p < 2; p++) begin
        inr[p] = ta[p] < dep[d];
        rv[p] = 1'b0; rd[p] = 8'h00; rk[p] = 1'b1;
        if (ten[p]) begin
          if (!inr[p]) begin
            rv[p] = 1'b1;
          end else if (!twe[p] || mode[d] == 2) begin
            rv[p] = 1'b1; rd[p] = m_mem[d][ta[p]]; rk[p] = m_known[d][ta[p]];
          end else if (mode[d] == 1) begin
            rv[p] = 1'b1; rd[p] = td[p];
          end
        end
      end
      rc = ten[0] && ten[1] && inr[0] && inr[1] && ta[0] == ta[1] && (twe[0] || twe[1]);
      ra = (ten[0] && !inr[0]) || (ten[1] && !inr[1]);
      if (ten[1] && twe[1] && inr[1] && !(ten[0] && twe[0] && inr[0] && ta[0] == ta[1])) begin
        m_mem[d][ta[1]] = td[1]; m_known[d][ta[1]] = 1'b1;
      end
      if (ten[0] && twe[0] && inr[0]) begin
        m_mem[d][ta[0]] = td[0]; m_known[d][ta[0]] = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (LAT == 1) begin
          e_v[d][p] = rv[p];
          if (rv[p]) begin e_d[d][p] = rd[p]; e_k[d][p] = rk[p]; end
        end else begin
          e_v[d][p] = p_v[d][p];
          if (p_v[d][p]) begin e_d[d][p] = p_d[d][p]; e_k[d][p] = p_k[d][p]; end
          p_v[d][p] = rv[p];
          if (rv[p]) begin p_d[d][p] = rd[p]; p_k[d][p] = rk[p]; end
        end
      end
      if (LAT == 1) begin
        e_c[d] = rc; e_a[d] = ra;
      end else begin
        e_c[d] = p_c[d]; e_a[d] = p_a[d]; p_c[d] = rc; p_a[d] = ra;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else if (!m_armed) begin
      m_armed = 1'b1;
      model_edge(1'b1);
    end else begin
      model_edge(1'b0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d valid_a", d), 32'(va[d]), 32'(e_v[d][0]));
      check($sformatf("d%0d valid_b", d), 32'(vb[d]), 32'(e_v[d][1]));
      if (e_k[d][0]) check($sformatf("d%0d data_out_a", d), 32'(dout_a[d]), 32'(e_d[d][0]));
      if (e_k[d][1]) check($sformatf("d%0d data_out_b", d), 32'(dout_b[d]), 32'(e_d[d][1]));
      check($sformatf("d%0d collision", d), 32'(col[d]), 32'(e_c[d]));
      check($sformatf("d%0d addr_err", d), 32'(aerr[d]), 32'(e_a[d]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int ea, input int wa, input int aa, input int da,
                     input int eb, input int wb, input int ab, input int db);
    en_a = ea[0]; we_a = wa[0]; addr_a = aa[5:0]; din_a = da[7:0];
    en_b = eb[0]; we_b = wb[0]; addr_b = ab[5:0]; din_b = db[7:0];
    $display("[TB] t=%0t A(en=%0d we=%0d addr=%0d din=0x%0h) B(en=%0d we=%0d addr=%0d din=0x%0h)",
             $time, en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush();
    for (int i = 0; i < LAT - 1; i++) idle();
  endtask

  int rd_addr [3] = '{5, 63, 0};

  initial begin
    model_reset();
    rst_n = 1'b0;
    en_a = 0; we_a = 0; addr_a = 0; din_a = 0;
    en_b = 0; we_b = 0; addr_b = 0; din_b = 0;
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset d%0d data_out_a", d), 32'(dout_a[d]), 32'h0);
      check($sformatf("reset d%0d valid_b", d), 32'(vb[d]), 32'h0);
    end
    rst_n = 1'b1;
    idle();

    // Preload mem[i] = i through port A.
    for (int i = 0; i < 64; i++) cyc(1, 1, i, i, 0, 0, 0, 0);

    // Consecutive port-B reads 5, 63, 0.
    for (int k = 0; k < 3 + LAT - 1; k++) begin
      if (k < 3) cyc(0, 0, 0, 0, 1, 0, rd_addr[k], 0);
      else idle();
      if (k >= LAT - 1) begin
        check("preload read data_out_b", 32'(dout_b[0]), 32'(rd_addr[k - LAT + 1]));
        check("preload read valid_b", 32'(vb[0]), 32'h1);
      end
    end

    // Same-port read-during-write on addr 10 (after a read of addr 3).
    cyc(1, 0, 3, 0, 0, 0, 0, 0);
    cyc(1, 1, 10, 8'hAA, 0, 0, 0, 0);
    flush();
    check("rdw NO_CHANGE data_out_a", 32'(dout_a[0]), 32'h03);
    check("rdw NO_CHANGE valid_a", 32'(va[0]), 32'h0);
    check("rdw WRITE_FIRST data_out_a", 32'(dout_a[1]), 32'hAA);
    check("rdw WRITE_FIRST valid_a", 32'(va[1]), 32'h1);
    check("rdw READ_FIRST data_out_a", 32'(dout_a[2]), 32'h0A);
    check("rdw READ_FIRST valid_a", 32'(va[2]), 32'h1);
    cyc(1, 0, 10, 0, 0, 0, 0, 0);
    flush();
    for (int d = 0; d < 3; d++) check($sformatf("rdw readback d%0d", d), 32'(dout_a[d]), 32'hAA);

    // Dual-write collision on addr 20.
    cyc(1, 1, 20, 8'h11, 1, 1, 20, 8'h22);
    flush();
    for (int d = 0; d < 3; d++) check($sformatf("dual write collision d%0d", d), 32'(col[d]), 32'h1);
    check("dual write WRITE_FIRST data_out_b", 32'(dout_b[1]), 32'h22);
    idle();
    check("collision pulse ends", 32'(col[0]), 32'h0);
    cyc(0, 0, 0, 0, 1, 0, 20, 0);
    flush();
    for (int d = 0; d < 3; d++) check($sformatf("dual write winner d%0d", d), 32'(dout_b[d]), 32'h11);

    // Write/read collision on addr 30.
    cyc(1, 1, 30, 8'h55, 1, 0, 30, 0);
    flush();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("wr/rd old data d%0d", d), 32'(dout_b[d]), 32'd30);
      check($sformatf("wr/rd collision d%0d", d), 32'(col[d]), 32'h1);
    end
    cyc(0, 0, 0, 0, 1, 0, 30, 0);
    flush();
    check("wr/rd new data", 32'(dout_b[0]), 32'h55);

    // Out-of-range write to addr 50 on the DEPTH=48 instance.
    cyc(1, 1, 50, 8'hFF, 0, 0, 0, 0);
    flush();
    check("oor addr_err", 32'(aerr[2]), 32'h1);
    check("oor data_out_a", 32'(dout_a[2]), 32'h0);
    check("oor valid_a", 32'(va[2]), 32'h1);
    check("in-range no addr_err", 32'(aerr[0]), 32'h0);
    for (int i = 0; i < 48; i++) cyc(0, 0, 0, 0, 1, 0, i, 0);
    flush();
    check("oor word 47 intact", 32'(dout_b[2]), 32'd47);

    // Mixed traffic on both ports.
    for (int i = 0; i < 60; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 255),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 255));

    // Reset in the middle of a port-B write burst.
    cyc(1, 1, 42, 8'h42, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 40, 8'hC0);
    cyc(0, 0, 0, 0, 1, 1, 41, 8'hC1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("async reset d%0d data_out_a", d), 32'(dout_a[d]), 32'h0);
      check($sformatf("async reset d%0d data_out_b", d), 32'(dout_b[d]), 32'h0);
      check($sformatf("async reset d%0d valid_a", d), 32'(va[d]), 32'h0);
      check($sformatf("async reset d%0d valid_b", d), 32'(vb[d]), 32'h0);
      check($sformatf("async reset d%0d collision", d), 32'(col[d]), 32'h0);
      check($sformatf("async reset d%0d addr_err", d), 32'(aerr[d]), 32'h0);
    end
    cyc(0, 0, 0, 0, 1, 1, 42, 8'hEE);
    cyc(0, 0, 0, 0, 1, 1, 42, 8'hEE);
    rst_n = 1'b1;
    idle();
    cyc(0, 0, 0, 0, 1, 0, 41, 0);
    flush();
    check("kept across reset 41", 32'(dout_b[0]), 32'hC1);
    cyc(0, 0, 0, 0, 1, 0, 42, 0);
    flush();
    for (int d = 0; d < 3; d++) check($sformatf("no write in reset d%0d", d), 32'(dout_b[d]), 32'h42);
    cyc(0, 0, 0, 0, 1, 0, 40, 0);
    flush();
    check("kept across reset 40", 32'(dout_b[0]), 32'hC0);

    repeat (LAT + 1) idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
